// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer that owns HI/LO. It computes the result at start,
// holds it in shadow registers for the op's latency, then commits it to HI/LO.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  // state | meaning
  // IDLE  | no op pending; mthi/mtlo accepted
  // RUN   | result held in shadow regs, counting down to commit
  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi_sh, lo_sh;
  logic               skip_commit;
  logic               load, commit, sw_wr;

  logic               is_div, is_signed, a_neg, b_neg, div_zero;
  logic [31:0]        abs_a, abs_b, divisor, quot, rem, quot_res, rem_res;
  logic [63:0]        prod;

  // One unsigned datapath serves both signednesses: multiply uses sign/zero
  // extension, divide works on magnitudes and fixes the signs afterwards.
  always_comb begin
    is_div    = md_op[1];
    is_signed = ~md_op[0];
    a_neg     = is_signed & src_a[31];
    b_neg     = is_signed & src_b[31];
    prod      = {{32{a_neg}}, src_a} * {{32{b_neg}}, src_b};
    abs_a     = a_neg ? (~src_a + 32'd1) : src_a;
    abs_b     = b_neg ? (~src_b + 32'd1) : src_b;
    div_zero  = (src_b == 32'd0);
    divisor   = div_zero ? 32'd1 : abs_b;
    quot      = abs_a / divisor;
    rem       = abs_a % divisor;
    quot_res  = (a_neg ^ b_neg) ? (~quot + 32'd1) : quot;
    rem_res   = a_neg ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    sw_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          sw_wr = 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          commit    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      hi_sh       <= '0;
      lo_sh       <= '0;
      skip_commit <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
    end else begin
      if (load) begin
        cnt         <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        hi_sh       <= is_div ? rem_res  : prod[63:32];
        lo_sh       <= is_div ? quot_res : prod[31:0];
        skip_commit <= is_div & div_zero;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      // A divide by zero still occupies the unit but leaves HI/LO untouched.
      if (commit) begin
        if (!skip_commit) begin
          hi_out <= hi_sh;
          lo_out <= lo_sh;
        end
      end else if (sw_wr) begin
        if (wr_hi) hi_out <= src_a;
        if (wr_lo) lo_out <= src_a;
      end
    end
  end

  assign busy     = (state == RUN);
  assign stall_md = d_md_use & (start | busy);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, wr_hi, wr_lo, d_md_use;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_md;
  logic [31:0] hi_out, lo_out;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .src_a(src_a), .src_b(src_b),
    .d_md_use(d_md_use), .busy(busy), .stall_md(stall_md),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || busy !== e.busy || stall_md !== e.stall ||
          hi_out !== e.hi || lo_out !== e.lo) begin
        errors++;
        $display("FAIL %s cyc %0d/%0d: got busy=%b stall=%b hi=%h lo=%h, expected busy=%b stall=%b hi=%h lo=%h",
                 e.name, cyc, e.cyc, busy, stall_md, hi_out, lo_out, e.busy, e.stall, e.hi, e.lo);
      end
    end
  end

  task automatic expect_now(input string name, input logic b, input logic s,
                            input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.cyc = cyc; e.name = name; e.busy = b; e.stall = s; e.hi = h; e.lo = l;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mt(input string name, input logic h_en, input logic l_en, input logic [31:0] val);
    wr_hi = h_en; wr_lo = l_en; src_a = val;
    expect_now(name, 1'b0, 1'b0, m_hi, m_lo);
    tick();
    wr_hi = 1'b0; wr_lo = 1'b0; src_a = 32'hDEAD_BEEF;
    if (h_en) m_hi = val;
    if (l_en) m_lo = val;
    expect_now({name, "_vis"}, 1'b0, 1'b0, m_hi, m_lo);
    tick();
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic use_d, input logic disturb,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    start = 1'b1; md_op = op; src_a = a; src_b = b; d_md_use = use_d;
    expect_now({name, "_start"}, 1'b0, use_d, m_hi, m_lo);
    tick();
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D;
    for (int i = 1; i <= n; i++) begin
      if (disturb && i == 2) begin
        start = 1'b1; md_op = 2'd3; wr_lo = 1'b1; src_a = 32'h1234; src_b = 32'h7;
      end
      expect_now($sformatf("%s_busy%0d", name, i), 1'b1, use_d, m_hi, m_lo);
      tick();
      start = 1'b0; wr_lo = 1'b0;
    end
    m_hi = new_hi; m_lo = new_lo;
    expect_now({name, "_done"}, 1'b0, 1'b0, m_hi, m_lo);
    tick();
    d_md_use = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; d_md_use = 1'b0;
    md_op = 2'd0; src_a = 32'h0; src_b = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    tick();
    tick();
    reset = 1'b0; d_md_use = 1'b1;
    expect_now("reset_state", 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    d_md_use = 1'b0;

    mt("mthi", 1'b1, 1'b0, 32'h11);
    mt("mtlo", 1'b0, 1'b1, 32'h22);
    run_op("mult_s",   2'd0, 32'hFFFF_FFFF, 32'h2, 5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",    2'd1, 32'hFFFF_FFFF, 32'h2, 5, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_nega", 2'd2, 32'hFFFF_FFF9, 32'h2, 10, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 2'd2, 32'h7, 32'hFFFF_FFFE, 10, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFD);
    run_op("divu",     2'd3, 32'h7, 32'h2, 10, 1'b0, 1'b0, 32'h1, 32'h3);
    run_op("div_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0, 32'h0, 32'h8000_0000);
    mt("mthi2", 1'b1, 1'b0, 32'h11);
    mt("mtlo2", 1'b0, 1'b1, 32'h22);
    run_op("div_zero", 2'd2, 32'h55, 32'h0, 10, 1'b1, 1'b0, 32'h11, 32'h22);
    run_op("mult_prot", 2'd0, 32'h3, 32'h4, 5, 1'b1, 1'b1, 32'h0, 32'hC);
    mt("mthi_abcd", 1'b1, 1'b0, 32'hABCD);
    mt("mt_both", 1'b1, 1'b1, 32'h77);
    wr_hi = 1'b1; wr_lo = 1'b1;
    run_op("mult_wr", 2'd0, 32'h2, 32'h3, 5, 1'b0, 1'b0, 32'h0, 32'h6);

    // reset in the middle of a pending mult discards the result
    start = 1'b1; md_op = 2'd0; src_a = 32'h3; src_b = 32'h4;
    expect_now("rst_mid_start", 1'b0, 1'b0, m_hi, m_lo);
    tick();
    start = 1'b0;
    expect_now("rst_mid_b1", 1'b1, 1'b0, m_hi, m_lo);
    tick();
    reset = 1'b1;
    expect_now("rst_mid_b2", 1'b1, 1'b0, m_hi, m_lo);
    tick();
    reset = 1'b0; m_hi = 32'h0; m_lo = 32'h0;
    for (int i = 3; i <= 7; i++) begin
      expect_now($sformatf("rst_mid_after%0d", i), 1'b0, 1'b0, m_hi, m_lo);
      tick();
    end

    repeat (3) tick();
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
